uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter NB_STOP, default 1, stop bits per frame (legal 1 or 2).
REQ-003 SHALL have parameter OVERSAMPLE, default 16, i_tick pulses per bit period (power of 2, >=8).
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 even, 1 odd (used only with UART_RX_PARITY_EN).
REQ-005 SHALL have port i_clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port i_tick  input  1  one-cycle oversample strobe from the external baud generator.
REQ-008 SHALL have port i_rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port o_data  output  NB_DATA  last received word, LSB received first.
REQ-010 SHALL have port o_data_valid  output  1  one-cycle pulse, frame complete.
REQ-011 SHALL have port o_framing_err  output  1  stop-bit error, qualified by o_data_valid.
REQ-012 SHALL have port o_parity_err  output  1  parity mismatch, qualified by o_data_valid.
REQ-013 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL pass i_rx through a 2-flop synchronizer; all FSM decisions use the synchronized value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; i_tick is ignored in IDLE.
REQ-016 IDLE: synchronized rx low -> START, tick counter cleared.
REQ-017 START: on the tick where the counter reaches OVERSAMPLE/2-1, sample rx; low -> DATA with counters cleared; high -> IDLE (false start, no o_data_valid).
REQ-018 DATA: each sample is taken after OVERSAMPLE ticks (mid-bit) and shifted in at the MSB, right shift; after NB_DATA samples -> PARITY if enabled, else STOP.
REQ-019 PARITY: sample once at mid-bit; compare with XOR of data bits (inverted if PARITY_ODD=1) -> PARITY_ERR flag; then STOP.
REQ-020 STOP: sample each of NB_STOP bits at mid-bit; any low sample sets the framing flag.
REQ-021 On the final stop-bit sample, SHALL go to IDLE immediately (no wait for end of bit), so back-to-back frames with zero idle time are received.
REQ-022 In the cycle after the final stop sample, o_data_valid SHALL be 1 for exactly one cycle with o_data, o_framing_err and o_parity_err all valid.
REQ-023 o_data SHALL hold its value until the next o_data_valid; error outputs SHALL be 0 whenever o_data_valid is 0.
REQ-024 A frame with a framing error SHALL still deliver its data with o_data_valid=1.
REQ-025 Tick counter width SHALL be $clog2(OVERSAMPLE); bit counter width SHALL be $clog2(NB_DATA+1); both wrap only via explicit clear.

Reset
REQ-026 i_reset SHALL force state IDLE, clear all counters and the shift register, and set synchronizer flops to 1.
REQ-027 During reset, o_data, o_data_valid, o_framing_err, o_parity_err and o_busy SHALL be 0; a frame in progress SHALL be discarded.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state present; one parity bit is expected after data.
REQ-029 Macro UART_RX_PARITY_EN undefined: no PARITY state or logic; DATA goes to STOP directly; o_parity_err is tied 0.

Structure
REQ-030 Package uart_pkg SHALL hold the state encoding (one-hot, 5 bits) and the PARITY_EVEN/PARITY_ODD constants.
REQ-031 The synchronizer SHALL be sub-module uart_sync2 (reset value 1).

Verification (NB_DATA=8, OVERSAMPLE=16, NB_STOP=1 unless stated)
REQ-032 Frame 0x55 8N1 -> one o_data_valid, o_data=0x55, both errors 0, o_busy low afterwards.
REQ-033 rx low for 4 ticks then high -> no o_data_valid, FSM back in IDLE, o_busy 0.
REQ-034 Frame 0xA3 with stop bit driven low -> o_data_valid, o_data=0xA3, o_framing_err=1.
REQ-035 With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 0 -> o_parity_err=1; parity bit 1 -> 0.
REQ-036 0x12 then 0x34 with zero idle, NB_STOP=2 -> two valid pulses, data 0x12 then 0x34, no errors.
REQ-037 Reset pulsed after data bit 3 of a frame, then frame 0xFF -> no valid for the aborted frame; o_data=0xFF for the next.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver slice.
//   state_t     : one-hot receiver FSM encoding (5 bits)
//   PARITY_EVEN : parity sense constant, even parity
//   PARITY_ODD  : parity sense constant, odd parity
package uart_pkg;

   typedef enum logic [4:0] {
      StIdle   = 5'b00001,
      StStart  = 5'b00010,
      StData   = 5'b00100,
      StParity = 5'b01000,
      StStop   = 5'b10000
   } state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_ext_if.sv
// uart_rx_ext_if -- received-word bundle from the UART receiver.
//   o_data        : last received word, LSB received first
//   o_data_valid  : one-cycle pulse, frame complete
//   o_framing_err : stop-bit error, qualified by o_data_valid
//   o_parity_err  : parity mismatch, qualified by o_data_valid
//   o_busy        : receiver is not idle
// master modport drives the bundle (receiver), slave modport observes it.
interface uart_rx_ext_if #(
   parameter int unsigned NB_DATA = 8
);

   logic [NB_DATA-1:0] o_data;
   logic               o_data_valid;
   logic               o_framing_err;
   logic               o_parity_err;
   logic               o_busy;

   modport master (
      output o_data, o_data_valid, o_framing_err, o_parity_err, o_busy
   );

   modport slave (
      input o_data, o_data_valid, o_framing_err, o_parity_err, o_busy
   );

endinterface

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for the idle-high serial line.
//   i_clock : clock, rising edge
//   i_reset : synchronous active-high reset, flops go to 1 (line idle)
//   i_d     : asynchronous input
//   o_q     : synchronized output
module uart_sync2 (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext -- oversampling UART receiver with external tick.
//   i_clock : sole clock, rising edge
//   i_reset : synchronous active-high reset
//   i_tick  : one-cycle oversample strobe (OVERSAMPLE per bit period)
//   i_rx    : asynchronous serial line, idle high
//   bus     : uart_rx_ext_if master (data, valid pulse, errors, busy)
// Optional feature: define UART_RX_PARITY_EN to expect one parity bit after
// the data bits (sense from PARITY_ODD); otherwise o_parity_err is tied 0.
module uart_rx_ext #(
   parameter int unsigned NB_DATA    = 8,
   parameter int unsigned NB_STOP    = 1,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_tick,
   input  logic          i_rx,
   uart_rx_ext_if.master bus
);

   import uart_pkg::*;

   localparam int unsigned NB_TICK = $clog2(OVERSAMPLE);
   localparam int unsigned NB_BIT  = $clog2(NB_DATA + 1);

   localparam logic [NB_TICK-1:0] TICK_HALF = NB_TICK'(OVERSAMPLE / 2 - 1);
   localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(OVERSAMPLE - 1);
   localparam logic [NB_BIT-1:0]  DATA_LAST = NB_BIT'(NB_DATA - 1);
   localparam logic [NB_BIT-1:0]  STOP_LAST = NB_BIT'(NB_STOP - 1);
   localparam logic PARITY_SENSE =
      (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : uart_pkg::PARITY_EVEN;

   logic               rx_sync;
   state_t             state_q, state_d;
   logic [NB_TICK-1:0] tick_cnt_q, tick_cnt_d;
   logic [NB_BIT-1:0]  bit_cnt_q, bit_cnt_d;
   logic [NB_DATA-1:0] shift_q, shift_d;
   logic               ferr_q, ferr_d;
   logic               done;
   logic [NB_DATA-1:0] data_q;
   logic               valid_q;
   logic               ferr_out_q;
`ifdef UART_RX_PARITY_EN
   logic               perr_q, perr_d;
   logic               perr_out_q;
`endif

   uart_sync2 u_sync (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rx_sync)
   );

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ferr_d     = ferr_q;
      done       = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d     = perr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!rx_sync) begin
               state_d    = StStart;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
               perr_d     = 1'b0;
`endif
            end
         end
         StStart: begin
            if (i_tick) begin
               if (tick_cnt_q == TICK_HALF) begin
                  // Mid start bit: a high line here was a glitch, drop it.
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = rx_sync ? StIdle : StData;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         StData: begin
            if (i_tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  shift_d    = {rx_sync, shift_q[NB_DATA-1:1]};
                  if (bit_cnt_q == DATA_LAST) begin
                     bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                     state_d   = StParity;
`else
                     state_d   = StStop;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (i_tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  perr_d     = rx_sync != ((^shift_q) ^ PARITY_SENSE);
                  state_d    = StStop;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
`endif
         StStop: begin
            if (i_tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  if (!rx_sync) begin
                     ferr_d = 1'b1;
                  end
                  // Leave on the last stop sample so a start bit that follows
                  // with no idle time is still caught.
                  if (bit_cnt_q == STOP_LAST) begin
                     bit_cnt_d = '0;
                     state_d   = StIdle;
                     done      = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ferr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ferr_q     <= ferr_d;
         valid_q    <= done;
         // Error outputs exist only alongside the valid pulse.
         ferr_out_q <= done & ferr_d;
         if (done) begin
            data_q <= shift_d;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         perr_q     <= 1'b0;
         perr_out_q <= 1'b0;
      end else begin
         perr_q     <= perr_d;
         perr_out_q <= done & perr_d;
      end
   end

   assign bus.o_parity_err = perr_out_q;
`else
   logic unused_parity_sense;
   assign unused_parity_sense = PARITY_SENSE;
   assign bus.o_parity_err    = 1'b0;
`endif

   assign bus.o_data        = data_q;
   assign bus.o_data_valid  = valid_q;
   assign bus.o_framing_err = ferr_out_q;
   assign bus.o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext -- directed self-checking bench for uart_rx_ext.
// Two receivers share clock and tick: u_dut1 (8N1) and u_dut2 (8 data, 2 stop).
// Expected words are queued when a frame is driven and popped on o_data_valid.
module tb_uart_rx_ext;

   localparam int OS       = 16;
   localparam int TICK_DIV = 4;

   typedef struct {
      logic [7:0] d;
      logic       f;
      logic       p;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic rx1 = 1'b1;
   logic rx2 = 1'b1;
   int   tick_div = 0;

   int   checks = 0;
   int   errors = 0;
   exp_t q1[$];
   exp_t q2[$];
   int   e1_cnt = 0;
   int   e2_cnt = 0;
   int   v1_cnt = 0;
   int   v2_cnt = 0;

   uart_rx_ext_if #(.NB_DATA(8)) bus1 ();
   uart_rx_ext_if #(.NB_DATA(8)) bus2 ();

   uart_rx_ext #(
      .NB_DATA    (8),
      .NB_STOP    (1),
      .OVERSAMPLE (OS),
      .PARITY_ODD (0)
   ) u_dut1 (
      .i_clock (clk),
      .i_reset (rst),
      .i_tick  (tick),
      .i_rx    (rx1),
      .bus     (bus1)
   );

   uart_rx_ext #(
      .NB_DATA    (8),
      .NB_STOP    (2),
      .OVERSAMPLE (OS),
      .PARITY_ODD (0)
   ) u_dut2 (
      .i_clock (clk),
      .i_reset (rst),
      .i_tick  (tick),
      .i_rx    (rx2),
      .bus     (bus2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tick_div == TICK_DIV - 1) begin
         tick_div <= 0;
         tick     <= 1'b1;
      end else begin
         tick_div <= tick_div + 1;
         tick     <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic busy_of(input int sel);
      return (sel == 1) ? bus1.o_busy : bus2.o_busy;
   endfunction

   // Drive one line level for a number of ticks.
   task automatic hold(input int sel, input logic v, input int ticks);
      if (sel == 1) rx1 = v;
      else          rx2 = v;
      repeat (ticks * TICK_DIV) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input int nstop,
                             input logic stop_v, input logic par_v);
      exp_t e;
      e.d = d;
      e.f = ~stop_v;
      e.p = (par_v != (^d));
      if (sel == 1) begin q1.push_back(e); e1_cnt++; end
      else          begin q2.push_back(e); e2_cnt++; end
      hold(sel, 1'b0, OS);
      chk("busy_in_frame", {31'd0, busy_of(sel)}, 32'd1);
      for (int i = 0; i < 8; i++) hold(sel, d[i], OS);
`ifdef UART_RX_PARITY_EN
      hold(sel, par_v, OS);
`endif
      for (int s = 0; s < nstop; s++) begin
         if (!stop_v) begin
            hold(sel, 1'b0, 10);
            hold(sel, 1'b1, OS - 10);
         end else begin
            hold(sel, 1'b1, OS);
         end
      end
   endtask

   task automatic drain(input int sel);
      for (int i = 0; i < 5000; i++) begin
         if (((sel == 1) ? q1.size() : q2.size()) == 0) break;
         @(posedge clk);
      end
      #1;
      chk("queue_drained", (sel == 1) ? q1.size() : q2.size(), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus1.o_data_valid) begin
         v1_cnt++;
         chk("dut1_expected_frame", {31'd0, q1.size() != 0}, 32'd1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("dut1_data", {24'd0, bus1.o_data}, {24'd0, e.d});
            chk("dut1_ferr", {31'd0, bus1.o_framing_err}, {31'd0, e.f});
            chk("dut1_perr", {31'd0, bus1.o_parity_err}, {31'd0, e.p});
         end
      end else if (!rst) begin
         chk("dut1_err_qual", {30'd0, bus1.o_framing_err, bus1.o_parity_err}, 32'd0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus2.o_data_valid) begin
         v2_cnt++;
         chk("dut2_expected_frame", {31'd0, q2.size() != 0}, 32'd1);
         if (q2.size() != 0) begin
            e = q2.pop_front();
            chk("dut2_data", {24'd0, bus2.o_data}, {24'd0, e.d});
            chk("dut2_ferr", {31'd0, bus2.o_framing_err}, {31'd0, e.f});
            chk("dut2_perr", {31'd0, bus2.o_parity_err}, {31'd0, e.p});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      // Reset state
      repeat (4) @(posedge clk);
      #1;
      chk("rst_data", {24'd0, bus1.o_data}, 32'd0);
      chk("rst_valid", {31'd0, bus1.o_data_valid}, 32'd0);
      chk("rst_ferr", {31'd0, bus1.o_framing_err}, 32'd0);
      chk("rst_perr", {31'd0, bus1.o_parity_err}, 32'd0);
      chk("rst_busy", {31'd0, bus1.o_busy}, 32'd0);
      chk("rst_busy2", {31'd0, bus2.o_busy}, 32'd0);
      rst = 1'b0;
      hold(1, 1'b1, 2 * OS);

      // Plain 8N1 frame
      send_frame(1, 8'h55, 1, 1'b1, ^8'h55);
      drain(1);
      repeat (20) @(posedge clk);
      #1;
      chk("busy_after_55", {31'd0, bus1.o_busy}, 32'd0);
      chk("data_hold_55", {24'd0, bus1.o_data}, 32'h55);

      // False start: short low pulse
      hold(1, 1'b0, 4);
      hold(1, 1'b1, 2 * OS);
      chk("false_start_busy", {31'd0, bus1.o_busy}, 32'd0);
      chk("false_start_novalid", v1_cnt, e1_cnt);

      // Framing error still delivers data
      send_frame(1, 8'hA3, 1, 1'b0, ^8'hA3);
      drain(1);
      hold(1, 1'b1, 2 * OS);
      chk("busy_after_a3", {31'd0, bus1.o_busy}, 32'd0);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit should be 1
      send_frame(1, 8'h07, 1, 1'b1, 1'b0);
      drain(1);
      hold(1, 1'b1, 2 * OS);
      send_frame(1, 8'h07, 1, 1'b1, 1'b1);
      drain(1);
      hold(1, 1'b1, 2 * OS);
`endif

      // Back-to-back frames, two stop bits, no idle between
      send_frame(2, 8'h12, 2, 1'b1, ^8'h12);
      send_frame(2, 8'h34, 2, 1'b1, ^8'h34);
      drain(2);
      hold(2, 1'b1, 2 * OS);
      chk("b2b_count", v2_cnt, 32'd2);
      chk("b2b_busy", {31'd0, bus2.o_busy}, 32'd0);

      // Reset after data bit 3 discards the frame
      d = 8'h5A;
      hold(1, 1'b0, OS);
      for (int i = 0; i < 4; i++) hold(1, d[i], OS);
      chk("abort_busy_before", {31'd0, bus1.o_busy}, 32'd1);
      rst = 1'b1;
      rx1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_rst_busy", {31'd0, bus1.o_busy}, 32'd0);
      chk("abort_rst_data", {24'd0, bus1.o_data}, 32'd0);
      chk("abort_rst_valid", {31'd0, bus1.o_data_valid}, 32'd0);
      rst = 1'b0;
      hold(1, 1'b1, 2 * OS);
      chk("abort_novalid", v1_cnt, e1_cnt);
      send_frame(1, 8'hFF, 1, 1'b1, ^8'hFF);
      drain(1);
      repeat (20) @(posedge clk);
      #1;
      chk("after_abort_data", {24'd0, bus1.o_data}, 32'hFF);
      chk("final_count1", v1_cnt, e1_cnt);
      chk("final_count2", v2_cnt, e2_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
